minicpu_ser_alu_seq: RTL
========================

Name: minicpu_ser_alu_seq

Overview:
- Parametrised, self-sequencing successor to the MiniCPU-S serial ALU.
- Holds a DEPTH-entry evaluation stack of N-bit registers (S0=A, S1=B, S2=C, ...). Executes one 5-bit MiniCPU-S opcode per Start/Done handshake.
- Runs an internal bit counter instead of relying on the CPU to count N clock enables.
- Sits beside the CPU sequencer and SPI memory interface. Exchanges operands bit-serially, LSB first.

Parameters:
- N, 16, data word width in bits (>=4).
- DEPTH, 3, evaluation stack depth (>=3).
- CW, clog2(N), width of the bit counter.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- Start  in  1  begin operation; sampled only in IDLE
- I  in  5  opcode; latched on accepted Start
- DI  in  1  serial data in from memory/SPI (LSB first)
- Op  in  1  serial operand register bit (LDK)
- W  in  1  serial workspace pointer bit (TWA)
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse
- DO  out  1  serial data out (A[0] during store-type ops)
- DO_En  out  1  DO valid
- CyO  out  1  carry flag
- Z  out  1  A==0 flag (optional feature)
- Ng  out  1  A[N-1] flag (optional feature)

Behaviour:
- Reset: Rst (synchronous, active-high) forces state IDLE and clears all stack entries, Cy, IR, counter, Busy, Done, DO, DO_En, Z and Ng to 0. Reset mid-operation aborts the operation; no Done is issued.
- States:
  - IDLE -> RUN on Start. Latch IR<=I, counter<=0, Busy<=1.
  - RUN: one bit per cycle. When counter==N-1, go to DONE.
  - DONE: Done=1 and Busy=0 for exactly one cycle, then IDLE.
- Latency: Start to Done = N+1 cycles for serial ops. RRC/RLC take 2 cycles (RUN lasts 1 cycle).
- Start while Busy or in DONE: ignored. Start in the same cycle as Done: ignored. Start the cycle after Done: accepted.
- Serial moves in RUN, per cycle, entries shift right with the new MSB as listed:
  - Push (LDK/LDL/LDNL/IN/INB/TWA/DUP): S0 takes Op/DI/DI/DI/DI/W/S0[0]; S(k) takes S(k-1)[0] for k>=1. Bottom entry is discarded.
  - Pop (STL/STNL/OUT/OUTB/TAW/POP): S(k) takes S(k+1)[0]; bottom entry recirculates itself (duplicates).
  - ADC/SBB/AND/ORL/XOR: S0 takes f(S1[0],S0[0]) and the remaining entries pop.
    - ADC: sum = S1[0]^S0[0]^Cy, carry = majority.
    - SBB: same with S0[0] inverted. Cy is not preset; the caller sets Cy.
    - Cy updates every bit for ADC/SBB; the final value is held.
  - XAB: S0 takes S1[0], S1 takes S0[0]; others recirculate.
  - RAS: S0 takes S2[0], S1 takes S0[0], S2 takes S1[0]; entries >=3 recirculate.
- RRC/RLC, single parallel cycle: {Cy,A}<= {A[0],Cy,A[N-1:1]} / {A[N-1],A[N-2:0],Cy}. Other entries unchanged.
- Non-ALU opcodes (CALL, NFX, PFX, BEQ, BLT, JMP, EXE, RTS, RTI, HLT): all entries recirculate for N cycles. Net state is unchanged and Done is still issued.
- DO/DO_En: DO=S0[0] and DO_En=1 in RUN for STL, STNL, OUT, OUTB and TAW. Otherwise DO=0 and DO_En=0. Outputs are never tristated.
- CyO reflects Cy directly.

Optional Feature:
- Macro SERALU_FLAGS_EN.
- Defined:
  - Z and Ng are registered and updated only on the DONE cycle from the final A.
  - Z is computed serially: a sticky OR of the bits written into S0[N-1] during RUN, cleared on Start. Z = ~OR.
  - Ng = A[N-1].
  - Both flags hold until the next DONE.
- Undefined: Z and Ng are tied to 0 and no flag logic is synthesised.

Test Plan:
- Reset mid-ADC at bit 7 (N=16) -> Busy=0, no Done, A=B=C=0, Cy=0 next cycle.
- LDK with Op stream 0x1234, then LDK 0x0FF0 -> A=0x0FF0, B=0x1234, C=0x0000; each Done exactly 17 cycles after Start.
- A=0x0001, B=0xFFFF, Cy=0, ADC -> A=0x0000, Cy=1, B=old C. With SERALU_FLAGS_EN: Z=1, Ng=0.
- A=0x0001, B=0x0000, Cy=1, SBB -> A=0xFFFF, Cy=0. Flags build: Ng=1, Z=0.
- STL with A=0xA5C3 -> DO emits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with DO_En=1 for 16 cycles; afterwards A=old B, C duplicated.
- RRC on A=0x8001, Cy=0 -> Done 2 cycles after Start, A=0x4000, Cy=1. Start asserted during Busy is ignored, and Start asserted on the Done cycle is ignored.

Source files
------------

// File: rtl/minicpu_ser_alu_seq.sv
// Self-sequencing bit-serial ALU with a DEPTH-entry evaluation stack (S0=A, S1=B, S2=C...).
// Optional Z/Ng flag registers are built only when SERALU_FLAGS_EN is defined.
module minicpu_ser_alu_seq #(
    parameter int N     = 16,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(N)
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [4:0] I,
    input  logic       DI,
    input  logic       Op,
    input  logic       W,
    output logic       Busy,
    output logic       Done,
    output logic       DO,
    output logic       DO_En,
    output logic       CyO,
    output logic       Z,
    output logic       Ng
);

    localparam logic [4:0] OP_LDK  = 5'd0,  OP_LDL  = 5'd1,  OP_LDNL = 5'd2,  OP_IN   = 5'd3;
    localparam logic [4:0] OP_INB  = 5'd4,  OP_TWA  = 5'd5,  OP_DUP  = 5'd6,  OP_STL  = 5'd7;
    localparam logic [4:0] OP_STNL = 5'd8,  OP_OUT  = 5'd9,  OP_OUTB = 5'd10, OP_TAW  = 5'd11;
    localparam logic [4:0] OP_POP  = 5'd12, OP_ADC  = 5'd13, OP_SBB  = 5'd14, OP_AND  = 5'd15;
    localparam logic [4:0] OP_ORL  = 5'd16, OP_XOR  = 5'd17, OP_XAB  = 5'd18, OP_RAS  = 5'd19;
    localparam logic [4:0] OP_RRC  = 5'd20, OP_RLC  = 5'd21;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [4:0]     r_ir;
    logic [CW-1:0]  r_cnt;
    logic           r_cy;
    logic           w_cy_nxt;
    logic [N-1:0]   r_stk     [DEPTH];
    logic [N-1:0]   w_stk_nxt [DEPTH];
    logic           w_bit;
    logic           w_opa;
    logic           w_par;
    logic           w_store;
    logic           w_last;

    function automatic logic [N-1:0] shr_in(input logic b, input logic [N-1:0] v);
        return {b, v[N-1:1]};
    endfunction

    assign w_par   = (r_ir == OP_RRC) || (r_ir == OP_RLC);
    assign w_store = (r_ir == OP_STL) || (r_ir == OP_STNL) || (r_ir == OP_OUT) ||
                     (r_ir == OP_OUTB) || (r_ir == OP_TAW);
    assign w_last  = w_par || (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-cycle stack datapath: every entry shifts right one bit with a new MSB.
    always_comb begin
        w_stk_nxt = r_stk;
        w_cy_nxt  = r_cy;
        w_bit     = 1'b0;
        w_opa     = 1'b0;
        if (r_state == S_RUN) begin
            case (r_ir)
                OP_LDK, OP_LDL, OP_LDNL, OP_IN, OP_INB, OP_TWA, OP_DUP: begin
                    case (r_ir)
                        OP_LDK:  w_bit = Op;
                        OP_TWA:  w_bit = W;
                        OP_DUP:  w_bit = r_stk[0][0];
                        default: w_bit = DI;
                    endcase
                    w_stk_nxt[0] = shr_in(w_bit, r_stk[0]);
                    for (int k = 1; k < DEPTH; k++)
                        w_stk_nxt[k] = shr_in(r_stk[k-1][0], r_stk[k]);
                end
                OP_STL, OP_STNL, OP_OUT, OP_OUTB, OP_TAW, OP_POP,
                OP_ADC, OP_SBB, OP_AND, OP_ORL, OP_XOR: begin
                    for (int k = 0; k < DEPTH - 1; k++)
                        w_stk_nxt[k] = shr_in(r_stk[k+1][0], r_stk[k]);
                    w_stk_nxt[DEPTH-1] = shr_in(r_stk[DEPTH-1][0], r_stk[DEPTH-1]);
                    w_opa = (r_ir == OP_SBB) ? ~r_stk[0][0] : r_stk[0][0];
                    case (r_ir)
                        OP_ADC, OP_SBB: begin
                            w_bit    = r_stk[1][0] ^ w_opa ^ r_cy;
                            w_cy_nxt = (r_stk[1][0] & w_opa) | (r_stk[1][0] & r_cy) | (w_opa & r_cy);
                        end
                        OP_AND:  w_bit = r_stk[1][0] & w_opa;
                        OP_ORL:  w_bit = r_stk[1][0] | w_opa;
                        OP_XOR:  w_bit = r_stk[1][0] ^ w_opa;
                        default: w_bit = r_stk[1][0];
                    endcase
                    if ((r_ir == OP_ADC) || (r_ir == OP_SBB) || (r_ir == OP_AND) ||
                        (r_ir == OP_ORL) || (r_ir == OP_XOR))
                        w_stk_nxt[0] = shr_in(w_bit, r_stk[0]);
                end
                OP_XAB: begin
                    for (int k = 2; k < DEPTH; k++)
                        w_stk_nxt[k] = shr_in(r_stk[k][0], r_stk[k]);
                    w_stk_nxt[0] = shr_in(r_stk[1][0], r_stk[0]);
                    w_stk_nxt[1] = shr_in(r_stk[0][0], r_stk[1]);
                end
                OP_RAS: begin
                    for (int k = 3; k < DEPTH; k++)
                        w_stk_nxt[k] = shr_in(r_stk[k][0], r_stk[k]);
                    w_stk_nxt[0] = shr_in(r_stk[2][0], r_stk[0]);
                    w_stk_nxt[1] = shr_in(r_stk[0][0], r_stk[1]);
                    w_stk_nxt[2] = shr_in(r_stk[1][0], r_stk[2]);
                end
                OP_RRC: begin
                    w_stk_nxt[0] = {r_cy, r_stk[0][N-1:1]};
                    w_cy_nxt     = r_stk[0][0];
                end
                OP_RLC: begin
                    w_stk_nxt[0] = {r_stk[0][N-2:0], r_cy};
                    w_cy_nxt     = r_stk[0][N-1];
                end
                default: begin
                    for (int k = 0; k < DEPTH; k++)
                        w_stk_nxt[k] = shr_in(r_stk[k][0], r_stk[k]);
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                r_stk[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cy    <= w_cy_nxt;
            for (int k = 0; k < DEPTH; k++)
                r_stk[k] <= w_stk_nxt[k];
            if ((r_state == S_IDLE) && Start) begin
                r_ir  <= I;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign Busy  = (r_state == S_RUN);
    assign Done  = (r_state == S_DONE);
    assign DO_En = (r_state == S_RUN) && w_store;
    assign DO    = DO_En ? r_stk[0][0] : 1'b0;
    assign CyO   = r_cy;

`ifdef SERALU_FLAGS_EN
    logic r_zor;
    logic r_z;
    logic r_ng;
    logic w_zbit;

    // Rotates write the whole new A at once, so all of it feeds the zero detector.
    assign w_zbit = w_par ? (|w_stk_nxt[0]) : w_stk_nxt[0][N-1];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_zor <= 1'b0;
            r_z   <= 1'b0;
            r_ng  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && Start)
                r_zor <= 1'b0;
            else if (r_state == S_RUN)
                r_zor <= r_zor | w_zbit;
            if (r_state == S_DONE) begin
                r_z  <= ~r_zor;
                r_ng <= r_stk[0][N-1];
            end
        end
    end

    assign Z  = r_z;
    assign Ng = r_ng;
`else
    assign Z  = 1'b0;
    assign Ng = 1'b0;
`endif

endmodule
